// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: grants one result producer per cycle and registers the CDB broadcast.
// Define CDB_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module cdb_arbiter #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned DATA_WIDTH    = 4,
    parameter int unsigned CDB_TAG_WIDTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*CDB_TAG_WIDTH-1:0] req_tag,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic                             cdb_out_valid,
    output logic [CDB_TAG_WIDTH-1:0]         cdb_out_tag,
    output logic [DATA_WIDTH-1:0]            cdb_out_data
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [CDB_TAG_WIDTH-1:0] tag_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0]    data_arr [NUM_REQ];

    logic [PTR_W-1:0] scan_base;
    logic [PTR_W-1:0] win_idx;
    logic             win_found;
    logic             xfer;
    int unsigned      cand;

    // Unpack the flat requester buses into per-requester words.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign tag_arr[g]  = req_tag[g*CDB_TAG_WIDTH +: CDB_TAG_WIDTH];
        assign data_arr[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

`ifdef CDB_ARB_FIXED_PRIO_EN
    assign scan_base = '0;
`else
    logic [PTR_W-1:0] rr_ptr;
    assign scan_base = rr_ptr;
`endif

    // Scan from scan_base upward with explicit modulo wrap; first valid requester wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = 32'(scan_base) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(cand);
            end
        end
    end

    assign xfer      = win_found && !flush && !rst;
    assign req_ready = xfer ? (NUM_REQ'(1) << win_idx) : '0;

    // Broadcast register: valid pulses for one cycle, tag/data hold between transfers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cdb_out_valid <= 1'b0;
            cdb_out_tag   <= '0;
            cdb_out_data  <= '0;
        end else begin
            cdb_out_valid <= xfer;
            if (xfer) begin
                cdb_out_tag  <= tag_arr[win_idx];
                cdb_out_data <= data_arr[win_idx];
            end
        end
    end

`ifndef CDB_ARB_FIXED_PRIO_EN
    // Pointer moves just past the winner; explicit wrap keeps it below NUM_REQ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (xfer) begin
            rr_ptr <= (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
        end
    end

    a_ptr_range: assert property (@(posedge clk) disable iff (rst) 32'(rr_ptr) < NUM_REQ);
`endif

    a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed vectors on a 4-requester and a 3-requester instance.
module tb_cdb_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        flush;
    logic [3:0]  req_valid;
    logic [15:0] req_tag;
    logic [15:0] req_data;
    logic [3:0]  req_ready;
    logic        cdb_out_valid;
    logic [3:0]  cdb_out_tag;
    logic [3:0]  cdb_out_data;

    logic        flush3;
    logic [2:0]  req_valid3;
    logic [11:0] req_tag3;
    logic [11:0] req_data3;
    logic [2:0]  req_ready3;
    logic        cdb_out_valid3;
    logic [3:0]  cdb_out_tag3;
    logic [3:0]  cdb_out_data3;

    cdb_arbiter #(.NUM_REQ(4), .DATA_WIDTH(4), .CDB_TAG_WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_tag(req_tag),
        .req_data(req_data), .req_ready(req_ready), .cdb_out_valid(cdb_out_valid),
        .cdb_out_tag(cdb_out_tag), .cdb_out_data(cdb_out_data)
    );

    cdb_arbiter #(.NUM_REQ(3), .DATA_WIDTH(4), .CDB_TAG_WIDTH(4)) u_dut3 (
        .clk(clk), .rst(rst), .flush(flush3), .req_valid(req_valid3), .req_tag(req_tag3),
        .req_data(req_data3), .req_ready(req_ready3), .cdb_out_valid(cdb_out_valid3),
        .cdb_out_tag(cdb_out_tag3), .cdb_out_data(cdb_out_data3)
    );

    typedef struct {
        logic [3:0] tag;
        logic [3:0] data;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Round-robin expectations come from the table; fixed priority picks the lowest set bit.
    function automatic logic [3:0] exp_grant4(input logic [3:0] v, input logic fl, input logic [3:0] rr);
        if (fl) return 4'b0000;
`ifdef CDB_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) if (v[i]) return 4'(1 << i);
        return 4'b0000;
`else
        return rr;
`endif
    endfunction

    function automatic logic [2:0] exp_grant3(input logic [2:0] v, input logic [2:0] rr);
`ifdef CDB_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 3; i++) if (v[i]) return 3'(1 << i);
        return 3'b000;
`else
        return rr;
`endif
    endfunction

    // Monitor: each presented broadcast must match the oldest expectation, one cycle after its grant.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (cdb_out_valid === 1'b1) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_bcast: got valid=1 tag=%0h expected valid=0", cdb_out_tag);
                end else begin
                    e = q.pop_front();
                    check("bcast_tag", 32'(cdb_out_tag), 32'(e.tag));
                    check("bcast_data", 32'(cdb_out_data), 32'(e.data));
                    check("bcast_latency", 32'(cyc), 32'(e.cyc + 1));
                end
            end
        end
    end

    // Called just after a posedge; drives one cycle and returns just after the next posedge.
    task automatic step4(input string name, input logic [3:0] v, input logic fl,
                         input logic [15:0] tags, input logic [15:0] datas, input logic [3:0] rr);
        logic [3:0] exp;
        exp_t       e;
        req_valid = v;
        flush     = fl;
        req_tag   = tags;
        req_data  = datas;
        @(negedge clk);
        exp = exp_grant4(v, fl, rr);
        check(name, 32'(req_ready), 32'(exp));
        for (int i = 0; i < 4; i++) begin
            if (exp[i]) begin
                e.tag  = tags[i*4 +: 4];
                e.data = datas[i*4 +: 4];
                e.cyc  = cyc;
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step3(input string name, input logic [2:0] v, input logic [2:0] rr);
        logic [2:0] exp;
        logic [3:0] etag;
        logic [3:0] edata;
        req_valid3 = v;
        @(negedge clk);
        exp   = exp_grant3(v, rr);
        etag  = 4'h0;
        edata = 4'h0;
        check(name, 32'(req_ready3), 32'(exp));
        for (int i = 0; i < 3; i++) begin
            if (exp[i]) begin
                etag  = req_tag3[i*4 +: 4];
                edata = req_data3[i*4 +: 4];
            end
        end
        @(posedge clk);
        #1;
        check({name, "_valid"}, 32'(cdb_out_valid3), 32'(exp != 3'b000));
        check({name, "_tag"}, 32'(cdb_out_tag3), 32'(etag));
        check({name, "_data"}, 32'(cdb_out_data3), 32'(edata));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        flush      = 1'b0;
        req_valid  = 4'b0000;
        req_tag    = 16'h0;
        req_data   = 16'h0;
        flush3     = 1'b0;
        req_valid3 = 3'b000;
        req_tag3   = 12'h321;
        req_data3  = 12'hCBA;
        repeat (2) @(posedge clk);
        #1;
        req_valid = 4'b1111;
        #1;
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_valid", 32'(cdb_out_valid), 32'h0);
        check("rst_tag", 32'(cdb_out_tag), 32'h0);
        check("rst_data", 32'(cdb_out_data), 32'h0);
        req_valid = 4'b0000;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single requester 2
        step4("single_req2", 4'b0100, 1'b0, 16'h0500, 16'h0900, 4'b0100);
        // Pointer now past requester 2
        step4("rr_from_ptr3", 4'b1111, 1'b0, 16'hA987, 16'h3C21, 4'b1000);

        // Async reset while a broadcast is on the bus and all requests pending
`ifdef CDB_ARB_FIXED_PRIO_EN
        check("pre_rst_tag", 32'(cdb_out_tag), 32'h7);
`else
        check("pre_rst_tag", 32'(cdb_out_tag), 32'hA);
`endif
        check("pre_rst_valid", 32'(cdb_out_valid), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_valid", 32'(cdb_out_valid), 32'h0);
        check("midrst_tag", 32'(cdb_out_tag), 32'h0);
        check("midrst_data", 32'(cdb_out_data), 32'h0);
        check("midrst_ready", 32'(req_ready), 32'h0);
        q.delete();
        @(posedge clk);
        #1;
        req_valid = 4'b0000;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // All requesting from reset: 0,1,2,3,0
        step4("all_c0", 4'b1111, 1'b0, 16'h4321, 16'h8765, 4'b0001);
        step4("all_c1", 4'b1111, 1'b0, 16'h5432, 16'h9876, 4'b0010);
        step4("all_c2", 4'b1111, 1'b0, 16'h6543, 16'hA987, 4'b0100);
        step4("all_c3", 4'b1111, 1'b0, 16'h7654, 16'hBA98, 4'b1000);
        step4("all_c4", 4'b1111, 1'b0, 16'h8765, 16'hCBA9, 4'b0001);

        // Flush blocks the grant and leaves the pointer where it was
        step4("flush", 4'b0011, 1'b1, 16'h00EF, 16'h0012, 4'b0000);
        check("flush_no_bcast", 32'(cdb_out_valid), 32'h0);
        step4("flush_resume", 4'b0011, 1'b0, 16'h00EF, 16'h0012, 4'b0010);
        step4("wrap_to_0", 4'b0011, 1'b0, 16'h1234, 16'h5678, 4'b0001);

        // Idle cycle: valid drops, tag/data hold
        step4("idle", 4'b0000, 1'b0, 16'hFFFF, 16'hFFFF, 4'b0000);
        check("idle_valid", 32'(cdb_out_valid), 32'h0);
        check("idle_tag_hold", 32'(cdb_out_tag), 32'h4);
        check("idle_data_hold", 32'(cdb_out_data), 32'h8);

        step4("ends_ptr1", 4'b1001, 1'b0, 16'hD00C, 16'h200B, 4'b1000);
        step4("ends_ptr0", 4'b1001, 1'b0, 16'hD00C, 16'h200B, 4'b0001);
        step4("mid_pair", 4'b0110, 1'b0, 16'h0AB0, 16'h0340, 4'b0010);
        step4("withdraw", 4'b0000, 1'b0, 16'h0000, 16'h0000, 4'b0000);

        // Three requesters: 2, then wrap to 0, then 1
        step3("n3_req2", 3'b100, 3'b100);
        step3("n3_wrap0", 3'b011, 3'b001);
        step3("n3_req1", 3'b011, 3'b010);
        req_valid3 = 3'b000;

        repeat (2) @(posedge clk);
        #1;
        check("bcast_drain", 32'(q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
